rect_fill_gen: RTL and testbench
================================

// Module: rect_fill_gen
// PURPOSE
//  Rectangle-fill raster engine; feeds the RF channel of the Y/X output muxes.
//  Takes two corner points and emits every pixel of the filled rectangle, one per accepted beat.
//  Order is row-major: y ascending, x ascending within a row.
//  Handshake: START/BUSY/DONE toward the command decoder, VALID/ADV toward the pixel writer.
// PARAMETERS
//  XW     10   width of x coordinates
//  YW     9    width of y coordinates (matches 9-bit mux Y bus)
//  H_RES  640  screen width in pixels (used only with RF_CLIP_EN)
//  V_RES  480  screen height in pixels (used only with RF_CLIP_EN)
// PORTS
//  CLK    in   1   system clock; all logic on posedge
//  RST    in   1   synchronous, active-high reset
//  START  in   1   command strobe; sampled only in IDLE
//  X0     in   XW  corner A x; sampled with START
//  Y0     in   YW  corner A y; sampled with START
//  X1     in   XW  corner B x; sampled with START
//  Y1     in   YW  corner B y; sampled with START
//  ADV    in   1   downstream accepted current pixel
//  xOut   out  XW  current pixel x (registered)
//  yOut   out  YW  current pixel y (registered)
//  VALID  out  1   xOut/yOut hold a pixel to be written
//  BUSY   out  1   high from the cycle after START until DONE
//  DONE   out  1   one-cycle pulse after the last pixel is accepted
// BEHAVIOUR
//  Reset: state=IDLE; xOut=0, yOut=0, VALID=0, BUSY=0, DONE=0. RST wins over all other inputs.
//  FSM states: IDLE -> SETUP -> RUN -> FIN -> IDLE.
//  IDLE
//   - START=1 latches X0..Y1 and goes to SETUP; BUSY=1 from the next cycle.
//  SETUP (1 cycle)
//   - Normalise corners: xl=min(X0,X1), xh=max(X0,X1), yl=min(Y0,Y1), yh=max(Y0,Y1).
//   - Load xOut=xl, yOut=yl, VALID=1, then go to RUN.
//   - First pixel is therefore visible 2 cycles after START.
//  RUN
//   - Beat = VALID & ADV. xOut/yOut/VALID are held while ADV=0.
//   - On a beat:
//     - xOut<xh: xOut+=1.
//     - else if yOut<yh: xOut=xl, yOut+=1.
//     - else (last pixel): VALID=0, go to FIN.
//   - At most one pixel per cycle; ADV continuously high gives 1 pixel/cycle.
//  FIN (1 cycle)
//   - DONE=1, BUSY=0 next cycle, return to IDLE.
//   - xOut/yOut keep the last pixel until the next SETUP.
//  Pixel count: exactly (xh-xl+1)*(yh-yl+1); degenerate (xl==xh and/or yl==yh) still emits a line or single point.
//  Arithmetic: unsigned; increments never exceed xh/yh, so no wrap at XW/YW limits (xh=2^XW-1 is legal).
//  START while BUSY: ignored, no queueing. ADV while VALID=0: ignored.
//  Reset mid-RUN: immediate return to IDLE, VALID=0, no DONE pulse.
// CONFIGURATION
//  RF_CLIP_EN defined
//   - SETUP clamps xh=min(xh,H_RES-1) and yh=min(yh,V_RES-1).
//   - If xl>=H_RES or yl>=V_RES, no pixel is emitted: SETUP goes straight to FIN (DONE still pulses, VALID stays 0).
//  RF_CLIP_EN undefined
//   - No clamping; every coordinate in the normalised box is emitted as given.
//   - H_RES/V_RES are unused.
// TESTING
//  T1 reset
//   - Assert RST during RUN.
//   - Next cycle: VALID=0, BUSY=0, xOut=0, yOut=0; no DONE.
//  T2 basic fill
//   - START with (2,3)-(4,4), ADV=1.
//   - VALID first at cycle+2; sequence (2,3)(3,3)(4,3)(2,4)(3,4)(4,4); DONE one cycle after the 6th beat.
//  T3 swapped corners plus stalls
//   - START with (4,4)-(2,3); toggle ADV 1/0.
//   - Same 6 pixels as T2; each held while ADV=0; no duplicates.
//  T4 single point
//   - START with (7,7)-(7,7).
//   - Exactly one pixel (7,7), then DONE.
//  T5 START while BUSY
//   - Pulse START with new corners mid-run.
//   - Running fill unaffected; count unchanged.
//  T6 clip (RF_CLIP_EN)
//   - (636,478)-(700,500) emits 4x2=8 pixels ending at (639,479).
//   - (650,10)-(660,20) emits 0 pixels with DONE pulse.
//   - Without the macro, (636,478)-(700,500) emits 65*23 pixels.

Source files
------------

// File: rtl/rect_fill_gen.sv
// Rectangle-fill raster engine: walks every pixel of the box spanned by two corners, row-major.
// Optional screen clipping is built when the RF_CLIP_EN macro is defined.
module rect_fill_gen #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [XW-1:0] X0,
  input  logic [YW-1:0] Y0,
  input  logic [XW-1:0] X1,
  input  logic [YW-1:0] Y1,
  input  logic          ADV,
  output logic [XW-1:0] xOut,
  output logic [YW-1:0] yOut,
  output logic          VALID,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] xl_q, xl_d, xh_q, xh_d;
  logic [YW-1:0] yl_q, yl_d, yh_q, yh_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Normalised box, derived from the raw corners held in xl/xh/yl/yh during SETUP.
  logic [XW-1:0] x_min, x_max;
  logic [YW-1:0] y_min, y_max;
  logic          box_empty;

  always_comb begin
    x_min = (xl_q < xh_q) ? xl_q : xh_q;
    x_max = (xl_q < xh_q) ? xh_q : xl_q;
    y_min = (yl_q < yh_q) ? yl_q : yh_q;
    y_max = (yl_q < yh_q) ? yh_q : yl_q;
    box_empty = 1'b0;
`ifdef RF_CLIP_EN
    if (int'(x_max) > H_RES - 1) x_max = XW'(H_RES - 1);
    if (int'(y_max) > V_RES - 1) y_max = YW'(V_RES - 1);
    box_empty = (int'(x_min) >= H_RES) || (int'(y_min) >= V_RES);
`endif
  end

  always_comb begin
    state_d = state_q;
    xl_d    = xl_q;
    xh_d    = xh_q;
    yl_d    = yl_q;
    yh_d    = yh_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          xl_d    = X0;
          xh_d    = X1;
          yl_d    = Y0;
          yh_d    = Y1;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        xl_d = x_min;
        xh_d = x_max;
        yl_d = y_min;
        yh_d = y_max;
        x_d  = x_min;
        y_d  = y_min;
        if (box_empty) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          valid_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Increments are bounded by xh/yh, so coordinates never wrap at the bus width.
        if (valid_q && ADV) begin
          if (x_q < xh_q) begin
            x_d = x_q + 1'b1;
          end else if (y_q < yh_q) begin
            x_d = xl_q;
            y_d = y_q + 1'b1;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      xl_q    <= '0;
      xh_q    <= '0;
      yl_q    <= '0;
      yh_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xl_q    <= xl_d;
      xh_q    <= xh_d;
      yl_q    <= yl_d;
      yh_q    <= yh_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign xOut  = x_q;
  assign yOut  = y_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_rect_fill_gen.sv
// Self-checking bench for rect_fill_gen: directed fills plus random fills against a pixel-list model.
module tb_rect_fill_gen;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  logic          CLK, RST, START, ADV;
  logic [XW-1:0] X0, X1, xOut;
  logic [YW-1:0] Y0, Y1, yOut;
  logic          VALID, BUSY, DONE;

  int n_checks = 0;
  int n_errors = 0;

  rect_fill_gen #(.XW(XW), .YW(YW), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .X0(X0), .Y0(Y0), .X1(X1), .Y1(Y1), .ADV(ADV),
    .xOut(xOut), .yOut(yOut), .VALID(VALID), .BUSY(BUSY), .DONE(DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int x, input int y);
    return 32'((x << YW) | y);
  endfunction

  // adv_mode: 0..100 = percent chance of ADV per cycle, -1 = alternate 1/0.
  task automatic run_fill(input string tag, input int x0, input int y0, input int x1, input int y1,
                          input int adv_mode, input bit mid_start);
    int  exp_q[$];
    int  xl, xh, yl, yh, cyc, last_beat, last_pix;
    bit  done_seen, empty, stalled;
    logic [31:0] held, exp_pix;

    xl = (x0 < x1) ? x0 : x1;  xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;  yh = (y0 < y1) ? y1 : y0;
    empty = 1'b0;
`ifdef RF_CLIP_EN
    if (xh > H_RES - 1) xh = H_RES - 1;
    if (yh > V_RES - 1) yh = V_RES - 1;
    empty = (xl >= H_RES) || (yl >= V_RES);
`endif
    if (!empty)
      for (int y = yl; y <= yh; y++)
        for (int x = xl; x <= xh; x++)
          exp_q.push_back(int'(pix(x, y)));
    last_pix = exp_q.size() > 0 ? exp_q[exp_q.size()-1] : 0;

    check({tag, "_idle_busy"}, 32'(BUSY), 0);
    X0 = XW'(x0); Y0 = YW'(y0); X1 = XW'(x1); Y1 = YW'(y1);
    START = 1'b1; ADV = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    X0 = XW'($urandom); Y0 = YW'($urandom); X1 = XW'($urandom); Y1 = YW'($urandom);
    check({tag, "_setup_busy"}, 32'(BUSY), 1);
    check({tag, "_setup_valid"}, 32'(VALID), 0);
    @(negedge CLK);
    check({tag, "_first_valid"}, 32'(VALID), empty ? 0 : 1);

    cyc = 0; last_beat = -1; done_seen = 1'b0; stalled = 1'b0; held = '0;
    while (!done_seen && cyc < 5000) begin
      if (stalled) check({tag, "_hold"}, 32'({xOut, yOut}), held);
      if (DONE) begin
        done_seen = 1'b1;
        check({tag, "_done_lat"}, 32'(cyc), 32'(last_beat + 1));
        check({tag, "_count_left"}, 32'(exp_q.size()), 0);
        check({tag, "_done_valid"}, 32'(VALID), 0);
      end else begin
        check({tag, "_run_busy"}, 32'(BUSY), 1);
        if (adv_mode < 0) ADV = (cyc % 2 == 0);
        else ADV = ($urandom_range(99) < adv_mode);
        if (mid_start && cyc == 3) begin
          START = 1'b1; X0 = 10'd100; Y0 = 9'd100; X1 = 10'd120; Y1 = 9'd130;
        end else begin
          START = 1'b0;
        end
        stalled = VALID && !ADV;
        held = 32'({xOut, yOut});
        if (VALID && ADV) begin
          exp_pix = exp_q.size() > 0 ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
          check({tag, "_pix"}, 32'({xOut, yOut}), exp_pix);
          last_beat = cyc;
        end
        @(negedge CLK);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(done_seen), 1);
    ADV = 1'b0; START = 1'b0;
    @(negedge CLK);
    check({tag, "_done_pulse"}, 32'(DONE), 0);
    check({tag, "_end_busy"}, 32'(BUSY), 0);
    if (!empty) check({tag, "_keep_last"}, 32'({xOut, yOut}), 32'(last_pix));
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check({tag, "_quiet_valid"}, 32'(VALID), 0);
    end
    $display("%s: (%0d,%0d)-(%0d,%0d) adv=%0d done after %0d cycles", tag, x0, y0, x1, y1,
             adv_mode, cyc);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; ADV = 1'b0;
    X0 = '0; Y0 = '0; X1 = '0; Y1 = '0;
    @(negedge CLK); @(negedge CLK);
    check("reset_valid", 32'(VALID), 0);
    check("reset_busy", 32'(BUSY), 0);
    check("reset_done", 32'(DONE), 0);
    check("reset_xy", 32'({xOut, yOut}), 0);
    RST = 1'b0;
    @(negedge CLK);

    // Reset in the middle of a fill.
    X0 = 10'd5; Y0 = 9'd5; X1 = 10'd20; Y1 = 9'd20; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; ADV = 1'b1;
    repeat (6) @(negedge CLK);
    check("midrun_valid", 32'(VALID), 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; ADV = 1'b0;
    check("rst_run_valid", 32'(VALID), 0);
    check("rst_run_busy", 32'(BUSY), 0);
    check("rst_run_xy", 32'({xOut, yOut}), 0);
    check("rst_run_done", 32'(DONE), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_no_done", 32'(DONE), 0);
    end
    $display("reset mid-run: outputs cleared");

    run_fill("basic", 2, 3, 4, 4, 100, 1'b0);
    run_fill("swap_stall", 4, 4, 2, 3, -1, 1'b0);
    run_fill("point", 7, 7, 7, 7, 100, 1'b0);
    run_fill("start_busy", 2, 3, 4, 4, 100, 1'b1);
    run_fill("hline", 9, 0, 3, 0, 60, 1'b0);
    run_fill("vline", 0, 8, 0, 2, 60, 1'b0);
    run_fill("max_edge", 1023, 510, 1021, 511, 70, 1'b0);
    run_fill("clip_box", 636, 478, 700, 500, 100, 1'b0);
    run_fill("off_screen", 650, 10, 660, 20, 100, 1'b0);
    for (int n = 0; n < 15; n++) begin
      int rx, ry;
      rx = $urandom_range(1023);
      ry = $urandom_range(511);
      run_fill("random", rx, ry,
               (rx + $urandom_range(12)) % 1024, (ry + $urandom_range(6)) % 512,
               $urandom_range(30, 100), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
